// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - FIFO-fed UART transmitter with configurable width, parity and stop bits
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_BITS-1:0]                 in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic                                 tx,
  output logic                                 busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = $clog2(CLKS_PER_BIT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;

  logic [2:0]           state_q, state_d;
  logic [DW-1:0]        div_q, div_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;

  logic                 push, pop, last_tick;
  logic [DATA_BITS-1:0] head;

  assign in_ready   = (count_q != CW'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign head       = mem_q[rd_ptr_q];
  assign last_tick  = (div_q == DW'(CLKS_PER_BIT - 1));
  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign fifo_count = count_q;

  always_comb begin
    state_d = state_q;
    div_d   = last_tick ? '0 : div_q + DW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        tx_d  = 1'b1;
        if (count_q != '0) pop = 1'b1;
      end
      S_START: begin
        if (last_tick) begin
          state_d = S_DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (last_tick) begin
          if (idx_q == 4'(DATA_BITS - 1)) begin
            idx_d = '0;
            if (PARITY != 0) begin
              state_d = S_PAR;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 4'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      S_PAR: begin
        if (last_tick) begin
          state_d = S_STOP;
          idx_d   = '0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (last_tick) begin
          if (idx_q == 4'(STOP_BITS - 1)) begin
            // Chain straight into the next start bit so queued words leave no idle gap
            if (count_q != '0) begin
              pop = 1'b1;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    if (pop) begin
      state_d = S_START;
      div_d   = '0;
      idx_d   = '0;
      tx_d    = 1'b0;
      shift_d = head;
      par_d   = (PARITY == 1) ? ~^head : ^head;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - scoreboard bench for uart_tx_frame across four parameter sets
module tb_uart_tx_frame;

  localparam int CPB = 4;

  typedef struct {
    logic [15:0] bits;
    int          n;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] in_data  [4];
  logic       in_valid [4];
  logic       in_ready [4];
  logic       tx_w     [4];
  logic       busy_w   [4];
  logic [2:0] cnt_w    [4];

  int db_t  [4] = '{8, 8, 8, 7};
  int par_t [4] = '{0, 2, 1, 0};
  int sb_t  [4] = '{1, 1, 1, 2};

  frame_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_8n1 (
    .clk(clk), .rst(rst), .in_data(in_data[0][7:0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(cnt_w[0]));
  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_even (
    .clk(clk), .rst(rst), .in_data(in_data[1][7:0]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(cnt_w[1]));
  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_odd (
    .clk(clk), .rst(rst), .in_data(in_data[2][7:0]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .tx(tx_w[2]), .busy(busy_w[2]), .fifo_count(cnt_w[2]));
  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_7n2 (
    .clk(clk), .rst(rst), .in_data(in_data[3][6:0]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .tx(tx_w[3]), .busy(busy_w[3]), .fifo_count(cnt_w[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame: start, data LSB first, optional parity, stop bits
  task automatic push_exp(input int s, input logic [8:0] d);
    frame_t f;
    logic   p;
    f.bits = '0;
    f.n    = 0;
    f.bits[f.n] = 1'b0;
    f.n++;
    p = 1'b0;
    for (int i = 0; i < db_t[s]; i++) begin
      f.bits[f.n] = d[i];
      p = p ^ d[i];
      f.n++;
    end
    if (par_t[s] != 0) begin
      f.bits[f.n] = (par_t[s] == 1) ? ~p : p;
      f.n++;
    end
    for (int i = 0; i < sb_t[s]; i++) begin
      f.bits[f.n] = 1'b1;
      f.n++;
    end
    exp_q.push_back(f);
  endtask

  task automatic rx_frame(input int s, input bit zero_gap);
    frame_t     f;
    int         waits;
    logic [3:0] samp;
    waits = 0;
    while (tx_w[s] !== 1'b0 && waits < 300) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 300) begin
      check($sformatf("start_timeout_dut%0d", s), 32'(waits), 32'd0);
      return;
    end
    if (zero_gap) check($sformatf("idle_gap_dut%0d", s), 32'(waits), 32'd0);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    f = exp_q.pop_front();
    for (int b = 0; b < f.n; b++) begin
      samp = '0;
      for (int c = 0; c < CPB; c++) begin
        samp[c] = tx_w[s];
        @(negedge clk);
      end
      check($sformatf("dut%0d_bit%0d", s, b), 32'(samp), f.bits[b] ? 32'hF : 32'h0);
    end
  endtask

  task automatic send_one(input int s, input logic [8:0] d);
    in_valid[s] = 1'b1;
    in_data[s]  = d;
    push_exp(s, d);
    @(negedge clk);
    in_valid[s] = 1'b0;
    check($sformatf("dut%0d_count_after_push", s), 32'(cnt_w[s]), 32'd1);
    check($sformatf("dut%0d_tx_before_pop", s), 32'(tx_w[s]), 32'd1);
    check($sformatf("dut%0d_busy_queued", s), 32'(busy_w[s]), 32'd1);
    @(negedge clk);
    check($sformatf("dut%0d_tx_low_e1", s), 32'(tx_w[s]), 32'd0);
    rx_frame(s, 1'b1);
    check($sformatf("dut%0d_busy_end", s), 32'(busy_w[s]), 32'd0);
    check($sformatf("dut%0d_tx_idle", s), 32'(tx_w[s]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  initial begin
    logic [8:0] w [6];
    int         idx;
    int         bad;
    bit         full_seen;
    logic       rdy;

    w = '{9'h03C, 9'h0C3, 9'h05A, 9'h081, 9'h0FF, 9'h066};
    for (int s = 0; s < 4; s++) begin
      in_valid[s] = 1'b0;
      in_data[s]  = '0;
    end
    repeat (2) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      check($sformatf("rst_tx_dut%0d", s), 32'(tx_w[s]), 32'd1);
      check($sformatf("rst_busy_dut%0d", s), 32'(busy_w[s]), 32'd0);
      check($sformatf("rst_ready_dut%0d", s), 32'(in_ready[s]), 32'd1);
      check($sformatf("rst_count_dut%0d", s), 32'(cnt_w[s]), 32'd0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    send_one(0, 9'h0A5);
    send_one(1, 9'h007);
    send_one(2, 9'h007);
    send_one(3, 9'h041);

    idx       = 0;
    full_seen = 1'b0;
    fork
      begin
        repeat (10) begin
          if (idx == 5 && !full_seen) begin
            check("fill_count_full", 32'(cnt_w[0]), 32'd4);
            check("fill_ready_low", 32'(in_ready[0]), 32'd0);
            full_seen = 1'b1;
          end
          in_valid[0] = (idx < 6);
          in_data[0]  = w[(idx < 6) ? idx : 5];
          rdy         = in_ready[0];
          @(posedge clk);
          if (rdy && idx < 6) begin
            push_exp(0, w[idx]);
            idx++;
          end
          @(negedge clk);
        end
        in_valid[0] = 1'b0;
        check("fill_accepted", 32'(idx), 32'd5);
      end
      begin
        rx_frame(0, 1'b0);
        for (int k = 1; k < 5; k++) rx_frame(0, 1'b1);
      end
    join
    check("fill_busy_end", 32'(busy_w[0]), 32'd0);
    check("fill_sb_drained", 32'(exp_q.size()), 32'd0);

    @(negedge clk);
    in_valid[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data[0] = w[k];
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    check("rst_mid_count_before", 32'(cnt_w[0]), 32'd2);
    repeat (16) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_tx", 32'(tx_w[0]), 32'd1);
    check("rst_mid_busy", 32'(busy_w[0]), 32'd0);
    check("rst_mid_count", 32'(cnt_w[0]), 32'd0);
    check("rst_mid_ready", 32'(in_ready[0]), 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad++;
    end
    check("rst_mid_quiet", 32'(bad), 32'd0);
    send_one(0, 9'h096);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
